// File: rtl/dma_pkg.sv
// Shared definitions for the DMA request unit:
// register addresses, control bit positions and controller states.
package dma_pkg;

  localparam logic [3:0] DMA_REQ_ADDR  = 4'b1001;
  localparam logic [3:0] DMA_MASK_ADDR = 4'b1010;
  localparam logic [3:0] DMA_STAT_ADDR = 4'b1000;

  // DataIn[2] chooses set (1) or clear (0) for request and mask writes.
  localparam int DMA_SET_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_SERVICE = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_priority_arbiter.sv
// Picks one requesting channel, searching upward from a start pointer.
// In fixed mode the search always starts at channel 0.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  input  logic              i_rot,
  output logic [CH_W-1:0]   o_grant,
  output logic              o_valid
);

  logic [CH_W-1:0] w_base;
  logic [CH_W-1:0] w_idx;

  assign w_base = i_rot ? i_ptr : '0;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = CH_W'((int'(w_base) + k) % NUM_CH);
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_request_unit.sv
// DMA request unit: software/hardware request capture, masking, terminal
// count status and the IDLE/HOLD/SERVICE bus hold handshake.
module dma_request_unit
  import dma_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         CH_W      = 2,
  parameter logic [3:0] REQ_ADDR  = DMA_REQ_ADDR,
  parameter logic [3:0] MASK_ADDR = DMA_MASK_ADDR,
  parameter logic [3:0] STAT_ADDR = DMA_STAT_ADDR
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IOR,
  input  logic              IOW,
  input  logic [3:0]        Address,
  input  logic [7:0]        DataIn,
  output logic [7:0]        DataOut,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] AutoInit,
  input  logic              RotPri,
  input  logic              HLDA,
  input  logic              EOP,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   ActiveCh,
  output logic              request_written
);

  dma_state_e        r_state, w_state_next;
  logic [CH_W-1:0]   r_active, r_ptr;
  logic [NUM_CH-1:0] r_dreq_s1, r_dreq_s2;
  logic              r_iow_d, r_req_written;
  logic [7:0]        r_data_out;

  logic [NUM_CH-1:0] w_sw_req, w_mask, w_tc, w_eff, w_dack;
  logic [7:0]        w_stat;
  logic [CH_W-1:0]   w_ch, w_grant;
  logic              w_ch_ok, w_grant_valid, w_latch, w_exit;
  logic              w_wr_ok, w_wr_req, w_wr_mask, w_rd_stat, w_eop_act;
  logic              w_unused_din;

  assign w_unused_din = ^DataIn;

  assign w_ch      = DataIn[CH_W-1:0];
  assign w_ch_ok   = int'(w_ch) < NUM_CH;
  assign w_wr_ok   = !IOW && IOR;
  assign w_wr_req  = w_wr_ok && (Address == REQ_ADDR);
  assign w_wr_mask = w_wr_ok && (Address == MASK_ADDR);
  assign w_rd_stat = !IOR && IOW && (Address == STAT_ADDR);
  assign w_eop_act = (r_state == ST_SERVICE) && EOP;
  assign w_eff     = (r_dreq_s2 | w_sw_req) & ~w_mask;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic r_sw_req, r_mask, r_tc;
      logic w_sel, w_eop_hit;

      assign w_sel     = w_ch_ok && (w_ch == CH_W'(gi));
      assign w_eop_hit = w_eop_act && (r_active == CH_W'(gi));

      // Terminal count outranks a coincident register write or status read.
      always_ff @(posedge CLK) begin
        if (Reset) begin
          r_sw_req <= 1'b0;
          r_mask   <= 1'b1;
          r_tc     <= 1'b0;
        end else begin
          if (w_eop_hit)
            r_sw_req <= 1'b0;
          else if (w_wr_req && w_sel)
            r_sw_req <= DataIn[DMA_SET_BIT];

          if (w_eop_hit && !AutoInit[gi])
            r_mask <= 1'b1;
          else if (w_wr_mask && w_sel)
            r_mask <= DataIn[DMA_SET_BIT];

          if (w_eop_hit)
            r_tc <= 1'b1;
          else if (w_rd_stat)
            r_tc <= 1'b0;
        end
      end

      assign w_sw_req[gi] = r_sw_req;
      assign w_mask[gi]   = r_mask;
      assign w_tc[gi]     = r_tc;
    end

    // Status word only has room for the first four channels.
    for (gi = 0; gi < 4; gi++) begin : g_stat
      if (gi < NUM_CH) begin : g_on
        assign w_stat[gi]     = w_tc[gi];
        assign w_stat[4 + gi] = w_eff[gi];
      end else begin : g_off
        assign w_stat[gi]     = 1'b0;
        assign w_stat[4 + gi] = 1'b0;
      end
    end
  endgenerate

  dma_priority_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .i_req   (w_eff),
    .i_ptr   (r_ptr),
    .i_rot   (RotPri),
    .o_grant (w_grant),
    .o_valid (w_grant_valid)
  );

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_exit       = 1'b0;
    case (r_state)
      ST_IDLE: if (|w_eff) w_state_next = ST_HOLD;
      ST_HOLD: begin
        if (!(|w_eff)) begin
          w_state_next = ST_IDLE;
        end else if (HLDA && w_grant_valid) begin
          w_state_next = ST_SERVICE;
          w_latch      = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (EOP || !w_eff[r_active]) begin
          w_state_next = ST_IDLE;
          w_exit       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_active      <= '0;
      r_ptr         <= '0;
      r_dreq_s1     <= '0;
      r_dreq_s2     <= '0;
      r_iow_d       <= 1'b1;
      r_req_written <= 1'b0;
      r_data_out    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_dreq_s1     <= DREQ;
      r_dreq_s2     <= r_dreq_s1;
      r_iow_d       <= IOW;
      r_req_written <= (w_wr_req || w_wr_mask) && r_iow_d;
      r_data_out    <= w_rd_stat ? w_stat : 8'h00;
      if (w_latch)
        r_active <= w_grant;
      // Served channel drops to lowest priority when rotating.
      if (w_exit)
        r_ptr <= RotPri ? CH_W'((int'(r_active) + 1) % NUM_CH) : '0;
    end
  end

  always_comb begin
    w_dack = '0;
    if (r_state == ST_SERVICE)
      w_dack[r_active] = 1'b1;
  end

  assign HRQ             = (r_state != ST_IDLE);
  assign DACK            = w_dack;
  assign ActiveCh        = r_active;
  assign DataOut         = r_data_out;
  assign request_written = r_req_written;

endmodule

// File: tb/tb_dma_request_unit.sv
// Directed self-checking bench for dma_request_unit (NUM_CH = 4).
module tb_dma_request_unit;

  logic       CLK = 1'b0;
  logic       Reset, IOR, IOW, RotPri, HLDA, EOP;
  logic [3:0] Address;
  logic [7:0] DataIn, DataOut;
  logic [3:0] DREQ, AutoInit, DACK;
  logic       HRQ, request_written;
  logic [1:0] ActiveCh;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] A_REQ  = 4'b1001;
  localparam logic [3:0] A_MASK = 4'b1010;
  localparam logic [3:0] A_STAT = 4'b1000;

  always #5 CLK = ~CLK;

  dma_request_unit dut (
    .CLK             (CLK),
    .Reset           (Reset),
    .IOR             (IOR),
    .IOW             (IOW),
    .Address         (Address),
    .DataIn          (DataIn),
    .DataOut         (DataOut),
    .DREQ            (DREQ),
    .AutoInit        (AutoInit),
    .RotPri          (RotPri),
    .HLDA            (HLDA),
    .EOP             (EOP),
    .HRQ             (HRQ),
    .DACK            (DACK),
    .ActiveCh        (ActiveCh),
    .request_written (request_written)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, act);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    Address = addr;
    DataIn  = data;
    IOW     = 1'b0;
    tick();
    IOW     = 1'b1;
    tick();
  endtask

  task automatic rd_stat(input string tag, input logic [7:0] exp);
    Address = A_STAT;
    IOR     = 1'b0;
    tick();
    IOR     = 1'b1;
    chk(tag, DataOut, exp);
  endtask

  task automatic wait_service(input string tag, input logic [1:0] ch);
    for (int i = 0; i < 20 && DACK == 4'b0000; i++) tick();
    chk({tag, "_active"}, ActiveCh, ch);
    chk({tag, "_dack"}, DACK, 4'b0001 << ch);
  endtask

  task automatic pulse_eop(input string tag);
    EOP = 1'b1;
    tick();
    EOP = 1'b0;
    chk({tag, "_hrq_after_eop"}, HRQ, 1'b0);
  endtask

  initial begin
    logic [1:0] rot_order [4] = '{2'd1, 2'd3, 2'd1, 2'd3};

    Reset = 1'b1; IOR = 1'b1; IOW = 1'b1; Address = 4'h0; DataIn = 8'h00;
    DREQ = 4'h0; AutoInit = 4'h0; RotPri = 1'b0; HLDA = 1'b0; EOP = 1'b0;
    tick(2);
    Reset = 1'b0;
    chk("rst_hrq", HRQ, 1'b0);
    chk("rst_dack", DACK, 4'h0);
    chk("rst_active", ActiveCh, 2'd0);
    chk("rst_dataout", DataOut, 8'h00);
    chk("rst_req_written", request_written, 1'b0);

    // Software request ch2 while still masked; strobe held two cycles.
    Address = A_REQ; DataIn = 8'h06; IOW = 1'b0;
    tick();
    chk("req_written_pulse", request_written, 1'b1);
    tick();
    chk("req_written_single", request_written, 1'b0);
    IOW = 1'b1;
    tick(2);
    chk("masked_hrq", HRQ, 1'b0);
    rd_stat("masked_status", 8'h00);

    // Unmask ch2 and run the hold handshake.
    wr(A_MASK, 8'h02);
    chk("hold_hrq", HRQ, 1'b1);
    chk("hold_dack", DACK, 4'h0);
    HLDA = 1'b1;
    tick();
    chk("svc2_dack", DACK, 4'b0100);
    chk("svc2_active", ActiveCh, 2'd2);
    rd_stat("svc2_status", 8'h40);
    wr(A_REQ, 8'h02);
    chk("swclr_hrq", HRQ, 1'b0);

    // Fixed priority, then rotating priority on DREQ = 1010.
    wr(A_MASK, 8'h01);
    wr(A_MASK, 8'h03);
    AutoInit = 4'b1111;
    DREQ     = 4'b1010;
    wait_service("fixed", 2'd1);
    pulse_eop("fixed");
    RotPri = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_service($sformatf("rot%0d", i), rot_order[i]);
      pulse_eop($sformatf("rot%0d", i));
    end
    DREQ = 4'b0000;
    tick(6);
    chk("drop_hrq", HRQ, 1'b0);
    rd_stat("tc_status", 8'h0A);
    rd_stat("tc_cleared", 8'h00);

    // Terminal count without auto-init re-masks ch1.
    AutoInit = 4'b0000;
    DREQ     = 4'b0010;
    wait_service("eop1", 2'd1);
    pulse_eop("eop1");
    tick(4);
    chk("eop1_masked_hrq", HRQ, 1'b0);
    rd_stat("eop1_status", 8'h02);
    rd_stat("eop1_status_again", 8'h00);
    DREQ = 4'b0000;

    // Reset in the middle of a service.
    wr(A_REQ, 8'h06);
    wait_service("rstsvc", 2'd2);
    Reset = 1'b1;
    tick();
    chk("rstsvc_hrq", HRQ, 1'b0);
    chk("rstsvc_dack", DACK, 4'h0);
    Reset = 1'b0;
    // Write with both strobes low must be ignored.
    Address = A_MASK; DataIn = 8'h00; IOW = 1'b0; IOR = 1'b0;
    tick();
    IOW = 1'b1; IOR = 1'b1;
    DREQ = 4'b1111;
    tick(5);
    chk("rstsvc_mask_all", HRQ, 1'b0);
    rd_stat("rstsvc_no_tc", 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_request_unit.md
DMA_REQUEST_UNIT -- requirements
Module: dma_request_unit

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DMA channels (2..8).
REQ-002 SHALL have parameter CH_W, default 2, channel index width, equal to clog2(NUM_CH).
REQ-003 SHALL have parameter REQ_ADDR, default 4'b1001, software request register address.
REQ-004 SHALL have parameter MASK_ADDR, default 4'b1010, single-channel mask register address.
REQ-005 SHALL have parameter STAT_ADDR, default 4'b1000, status register read address.
REQ-006 SHALL have port CLK, input, 1 bit, system clock; all state updates on the rising edge.
REQ-007 SHALL have port Reset, input, 1 bit, synchronous, active-high.
REQ-008 SHALL have port IOR, input, 1 bit, active-low read strobe.
REQ-009 SHALL have port IOW, input, 1 bit, active-low write strobe.
REQ-010 SHALL have port Address, input, 4 bits, register select.
REQ-011 SHALL have port DataIn, input, 8 bits, write data.
REQ-012 SHALL have port DataOut, output, 8 bits, read data.
REQ-013 SHALL have port DREQ, input, NUM_CH bits, asynchronous hardware requests, active-high.
REQ-014 SHALL have port AutoInit, input, NUM_CH bits, per-channel auto-initialisation enable.
REQ-015 SHALL have port RotPri, input, 1 bit: 0 = fixed priority (channel 0 highest), 1 = rotating priority.
REQ-016 SHALL have port HLDA, input, 1 bit, bus hold acknowledge.
REQ-017 SHALL have port EOP, input, 1 bit, terminal count for the serviced channel.
REQ-018 SHALL have port HRQ, output, 1 bit, bus hold request.
REQ-019 SHALL have port DACK, output, NUM_CH bits, one-hot acknowledge.
REQ-020 SHALL have port ActiveCh, output, CH_W bits, index of the serviced channel.
REQ-021 SHALL have port request_written, output, 1 bit, single-cycle write-accepted pulse.

Function
REQ-022 Write SHALL be accepted when IOW=0, IOR=1 and Address matches; request_written SHALL pulse for one cycle on the first accepted cycle only (falling IOW edge detect).
REQ-023 Write to REQ_ADDR: DataIn[CH_W-1:0] selects the channel; DataIn[2] =1 sets, =0 clears its software-request bit; out-of-range channel index ignored.
REQ-024 Write to MASK_ADDR: same channel select; DataIn[2] sets or clears its mask bit.
REQ-025 DREQ SHALL pass through a two-flop synchroniser; effective request = (sync DREQ OR software request) AND NOT mask.
REQ-026 Read (IOR=0, IOW=1, Address=STAT_ADDR) SHALL drive DataOut = {effective requests in [7:4], TC-reached flags in [3:0]} zero-extended; TC flags clear on that read; otherwise DataOut=0.
REQ-027 FSM states IDLE, HOLD, SERVICE.
REQ-028 IDLE->HOLD when any effective request; HRQ=1 in HOLD and SERVICE.
REQ-029 HOLD->SERVICE when HLDA=1; the winning channel is latched into ActiveCh and DACK asserts one-hot from the next cycle; HOLD->IDLE if all requests drop before HLDA.
REQ-030 SERVICE->IDLE on EOP=1 or when the active channel's effective request drops; DACK=0 in IDLE and HOLD.
REQ-031 On EOP: active channel software request cleared, TC flag set, mask bit set unless AutoInit[ActiveCh]=1.
REQ-032 Rotating mode: after SERVICE exit, the served channel becomes lowest priority; fixed mode pointer stays at channel 0.
REQ-033 A write to the active channel's request or mask bit during SERVICE SHALL take effect the same edge; a clear ends service per REQ-030.
REQ-034 A write coincident with EOP on the same bit: EOP clear wins.

Reset
REQ-035 On Reset: FSM IDLE, software requests 0, mask all 1s, TC flags 0, priority pointer 0, synchronisers 0, HRQ=0, DACK=0, ActiveCh=0, DataOut=0, request_written=0.
REQ-036 Reset in SERVICE SHALL drop HRQ and DACK on the next edge without setting TC.

Structure
REQ-037 Shared package dma_pkg SHALL hold default register addresses, FSM state enum, and DataIn bit positions (set/clear bit 2).
REQ-038 Priority selection SHALL be sub-module dma_priority_arbiter (requests, pointer, mode in; grant index and valid out).

Verification
REQ-039 Reset, write REQ_ADDR data 8'h06 -> request_written one pulse; channel 2 software request set; mask still blocks, HRQ=0.
REQ-040 Clear mask ch2 (8'h02 to MASK_ADDR), HLDA=1 -> HRQ=1, then DACK=4'b0100, ActiveCh=2.
REQ-041 Fixed mode, DREQ=4'b1010 -> ch1 served; rotating mode, repeated requests -> order 1,3,1,3.
REQ-042 EOP during ch1 service with AutoInit[1]=0 -> IDLE, mask[1]=1, status read DataOut[1]=1 then 0 on second read.
REQ-043 Reset asserted mid-SERVICE -> next edge HRQ=0, DACK=0, mask=4'b1111.
